handshake_constant_check: RTL
=============================

# handshake_constant_check

- Handshake sink that receives data tokens and checks each against a compile-time constant.
- Converts each data token into a 1-bit control token carrying the comparison result; this is the receive-side counterpart of the constant-generator component.
- Sits at the consumer end of a dataflow channel: absorbs tokens, decouples backpressure through a 2-entry elastic buffer, and keeps saturating token/mismatch statistics for on-chip debug.

## Interface

Parameters:
- DATA_WIDTH, 32, width of the incoming data token
- CONSTANT, {DATA_WIDTH{1'b0}}, expected value, DATA_WIDTH bits
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- ins  input  DATA_WIDTH  incoming data token
- ins_valid  input  1  producer has a token
- ins_ready  output  1  block can accept a token
- outs  output  1  result token: 1 = data equalled CONSTANT
- outs_valid  output  1  result token available
- outs_ready  input  1  consumer accepts result token
- tokens_seen  output  CNT_WIDTH  accepted-token count, saturating
- mismatch_cnt  output  CNT_WIDTH  mismatching-token count, saturating
- error  output  1  sticky, set on the first mismatch

## Operation

- **Accept:** an input transfer happens when ins_valid && ins_ready.
  - Comparison is combinational at accept: match = (ins == CONSTANT), full DATA_WIDTH, unsigned bitwise equality.
  - Only the 1-bit match result is stored; the data itself is discarded.
- **Buffer:** 2-entry FIFO of match bits.
  - Write pointer and read pointer are 1 bit each and wrap 1→0.
  - Occupancy states are EMPTY(0), ONE(1), FULL(2).
  - Transitions:
    - EMPTY: accept → ONE.
    - ONE: accept without drain → FULL; drain without accept → EMPTY; both → ONE.
    - FULL: drain → ONE. No accept is possible while FULL.
- **Handshake outputs:**
  - ins_ready = (state != FULL), registered. It does not depend on outs_ready (no combinational ready path).
  - outs_valid = (state != EMPTY); outs = entry at the read pointer.
  - Output transfer happens when outs_valid && outs_ready.
- **Statistics:**
  - tokens_seen increments on every accept.
  - mismatch_cnt increments on every accept with match = 0.
  - Both saturate at 2^CNT_WIDTH−1 and do not wrap.
  - error sets on the first mismatching accept and stays set until rst.
- **Producer rules:** ins and ins_valid must stay stable while ins_valid && !ins_ready. The block does not check this.

## Timing

- **Reset values:**
  - ins_ready = 1
  - outs_valid = 0
  - outs = 0
  - tokens_seen = 0
  - mismatch_cnt = 0
  - error = 0
  - state EMPTY, both pointers 0.
- **Latency:** a token accepted at edge N gives outs_valid = 1 after edge N; the consumer can take it at edge N+1.
- **Throughput:** 1 token/cycle sustained when outs_ready is held 1.
- **Simultaneous accept and drain in ONE:** occupancy unchanged, both pointers advance. outs shows the older entry first, so order is preserved.
- **FULL with outs_ready = 0:** ins_ready = 0, the entries are held and outs is stable.
- **outs_valid stability:** once asserted, outs_valid stays high until the transfer completes. outs does not change while outs_valid && !outs_ready.
- **Statistics timing:** counters and error update on the same edge as the accept and are visible the next cycle.
- **Saturation:** a counter at its maximum value holds. tokens_seen and mismatch_cnt saturate independently.
- **rst asserted mid-operation:** buffered tokens are dropped. All outputs return to reset values on the next edge, with no partial drain.

## Structure

- Shared handshake package holds:
  - occupancy-state encoding: EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2
  - a saturating-increment function, also reused by other statistics blocks.
- One natural sub-module: `handshake_tehb2_bit`, the generic 2-entry elastic buffer with registered ready, parameterised on payload width (instantiated here with width 1).
- The top level adds the comparator, the counters and the sticky flag.

## Test plan

Configuration for all scenarios: DATA_WIDTH=8, CONSTANT=8'hA5, CNT_WIDTH=4.

- **Single match:** after reset, one token ins = 8'hA5 with outs_ready = 1 → outs_valid next cycle with outs = 1; tokens_seen = 1, mismatch_cnt = 0, error = 0.
- **Backpressure and order:** outs_ready = 0, send 8'h00 then 8'hA5 → ins_ready drops after the second accept. A third token is held with no accept. Releasing outs_ready yields outs 0 then 1 in order; mismatch_cnt = 1, error = 1.
- **Streaming:** 20 back-to-back tokens alternating 8'hA5 / 8'h5A, outs_ready = 1 → one result per cycle, pattern 1,0,1,0…; tokens_seen saturates at 15, mismatch_cnt = 10.
- **Simultaneous accept and drain in ONE:** occupancy stays 1, ins_ready stays 1, no token lost or duplicated.
- **Reset while FULL:** with error = 1, assert rst for one cycle → outs_valid = 0, ins_ready = 1, counters = 0, error = 0. The next token 8'hA5 yields outs = 1.

Source files
------------

// File: rtl/handshake_constant_check_pkg.sv
// handshake_constant_check_pkg: occupancy encoding and saturating increment shared by handshake blocks
package handshake_constant_check_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/handshake_constant_check_tehb2_bit.sv
// handshake_tehb2_bit: 2-entry elastic buffer with ready derived only from registered occupancy
module handshake_tehb2_bit
  import handshake_constant_check_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  occ_t state, state_nxt;
  logic [W-1:0] mem [2];
  logic wp, rp, acc, drn;
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data = mem[rp];
  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;
  always_comb begin
    state_nxt = state;
    state_nxt = (acc && !drn) ? occ_t'(state + 2'd1) : (drn && !acc) ? occ_t'(state - 2'd1) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      wp <= 1'b0;
      rp <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        mem[wp] <= in_data;
        wp <= ~wp;
      end
      if (drn) rp <= ~rp;
    end
  end
endmodule

// File: rtl/handshake_constant_check.sv
// handshake_constant_check: turns each data token into a match-against-constant bit with debug statistics
module handshake_constant_check
  import handshake_constant_check_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] CONSTANT = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  tokens_seen,
  output logic [CNT_WIDTH-1:0]  mismatch_cnt,
  output logic                  error
);
  localparam logic [CNT_WIDTH-1:0] cnt_max = '1;
  logic match, acc;
  assign match = ins == CONSTANT;
  assign acc = ins_valid && ins_ready;
  handshake_tehb2_bit #(.W(1)) u_buf (
    .clk(clk),
    .rst(rst),
    .in_data(match),
    .in_valid(ins_valid),
    .in_ready(ins_ready),
    .out_data(outs),
    .out_valid(outs_valid),
    .out_ready(outs_ready)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      tokens_seen <= '0;
      mismatch_cnt <= '0;
      error <= 1'b0;
    end else if (acc) begin
      tokens_seen <= CNT_WIDTH'(sat_inc(32'(tokens_seen), 32'(cnt_max)));
      if (!match) begin
        mismatch_cnt <= CNT_WIDTH'(sat_inc(32'(mismatch_cnt), 32'(cnt_max)));
        error <= 1'b1;
      end
    end
  end
endmodule
